// File: rtl/io_pkg.sv
// Shared types and constants for the switch-input stall block and the MMIO decode that
// drives its read request.
package io_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWaitRelease,
      StWaitPress,
      StDone
   } io_state_e;

   // 10 ms at 100 MHz, and 5 s at 100 MHz
   localparam int unsigned IO_DEBOUNCE_DEFAULT = 1_000_000;
   localparam int unsigned IO_TIMEOUT_DEFAULT  = 500_000_000;

   // Load from this address is decoded into io_rd_req
   localparam logic [31:0] IO_SW_ADDR = 32'hFFFF_FC70;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for a raw push button, with a one-cycle
// pulse on each accepted rising edge.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = io_pkg::IO_DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic stable,
   output logic rise_pulse
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q;
   logic            sync2_q;
   logic            stable_q;
   logic            stable_dly_q;
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         stable_dly_q <= stable_q;
         // Any return to the accepted level restarts the count, so short glitches vanish
         if (sync2_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntMax) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

   assign stable     = stable_q;
   assign rise_pulse = stable_q & ~stable_dly_q;

endmodule

// File: rtl/io_input_stall.sv
// Stalls the pipeline on a switch-port read until a fresh debounced Enter press, then
// returns the captured switches. Optional wait timeout enabled by IO_STALL_TIMEOUT_EN.
module io_input_stall
   import io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
   parameter int unsigned SW_WIDTH        = 16,
   parameter int unsigned TIMEOUT_CYCLES  = IO_TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enter_btn,
   input  logic [SW_WIDTH-1:0] sw,
   input  logic                io_rd_req,
   output logic                stall_req_io,
   output logic [31:0]         io_rdata,
   output logic                enter_pulse,
   output logic                io_timeout
);

   if (SW_WIDTH == 0 || SW_WIDTH > 32 || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("io_input_stall: SW_WIDTH must be 1..32 and TIMEOUT_CYCLES nonzero");
   end

   logic                btn_stable;
   logic                enter_rise;
   logic [SW_WIDTH-1:0] sw_meta_q;
   logic [SW_WIDTH-1:0] sw_sync_q;
   logic [31:0]         sw_ext;
   logic [31:0]         rdata_q;
   io_state_e           state_q;
   logic                waiting;
   logic                go_press;
   logic                capture;
   logic                timeout_hit;
   logic                take_timeout;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_enter_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (enter_btn),
      .stable    (btn_stable),
      .rise_pulse(enter_rise)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
      end
   end

   always_comb begin
      sw_ext                 = '0;
      sw_ext[SW_WIDTH-1:0]   = sw_sync_q;
   end

   always_comb begin
      waiting      = (state_q == StWaitRelease) || (state_q == StWaitPress);
      go_press     = (state_q == StWaitRelease) && io_rd_req && !btn_stable;
      capture      = (state_q == StWaitPress) && io_rd_req && enter_rise;
      take_timeout = waiting && io_rd_req && timeout_hit && !go_press && !capture;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         rdata_q <= '0;
      end else begin
         unique case (state_q)
            // A level that is already high must be released first, never taken as a press
            StIdle: begin
               if (io_rd_req) begin
                  state_q <= btn_stable ? StWaitRelease : StWaitPress;
               end
            end
            StWaitRelease, StWaitPress: begin
               if (!io_rd_req) begin
                  state_q <= StIdle;
               end else if (go_press) begin
                  state_q <= StWaitPress;
               end else if (capture) begin
                  rdata_q <= sw_ext;
                  state_q <= StDone;
               end else if (take_timeout) begin
                  rdata_q <= '0;
                  state_q <= StDone;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef IO_STALL_TIMEOUT_EN
   localparam int unsigned TimeoutW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TimeoutW-1:0] TimeoutMax = TimeoutW'(TIMEOUT_CYCLES - 1);

   logic [TimeoutW-1:0] wait_cnt_q;
   logic                timeout_q;
   logic                wait_enter;

   assign wait_enter  = ((state_q == StIdle) && io_rd_req) || go_press;
   assign timeout_hit = (wait_cnt_q == TimeoutMax);
   assign io_timeout  = timeout_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         if (wait_enter) begin
            wait_cnt_q <= '0;
         end else if (waiting && !timeout_hit) begin
            wait_cnt_q <= wait_cnt_q + TimeoutW'(1);
         end
         if (capture) begin
            timeout_q <= 1'b0;
         end else if (take_timeout) begin
            timeout_q <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign io_timeout  = 1'b0;
`endif

   // Combinational so the stall covers the very first cycle of the read
   assign stall_req_io = rst_n & io_rd_req & (state_q != StDone);
   assign io_rdata     = rdata_q;
   assign enter_pulse  = enter_rise;

endmodule
